regs_wb_scheduler: RTL and testbench

// Sequences all access to the 32x32 register file: schedules operand reads for

---
 rtl/regs_wb_scheduler.sv | 148 ++++++++++++++
 tb/tb_regs_wb_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_scheduler.sv
// Register file access sequencer: operand read scheduling, ALU/LSU write-port
// arbitration and a per-register busy scoreboard for RAW/WAW issue stalls.
module regs_wb_scheduler #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   iss_valid,
    input  logic [REG_AW-1:0]      iss_rs1,
    input  logic [REG_AW-1:0]      iss_rs2,
    input  logic                   iss_rs1_used,
    input  logic                   iss_rs2_used,
    input  logic [REG_AW-1:0]      iss_rd,
    output logic                   iss_ready,
    input  logic                   alu_valid,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    output logic                   alu_ready,
    input  logic                   lsu_valid,
    input  logic [REG_AW-1:0]      lsu_rd,
    input  logic [XLEN-1:0]        lsu_data,
    output logic                   lsu_ready,
    output logic [REG_AW-1:0]      rf_rs1_out,
    output logic [REG_AW-1:0]      rf_rs2_out,
    output logic                   rf_rs_read_n,
    output logic [REG_AW-1:0]      rf_rd_out,
    output logic [XLEN-1:0]        rf_rd_value_out,
    output logic                   rf_rd_write_n,
    output logic [(2**REG_AW)-1:0] busy_out
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    logic [NREG-1:0]   busy_q, busy_d;
    logic [NREG-1:0]   set_vec, clr_vec;
    grant_e            last_grant_q, last_grant_d;

    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic              read_n_q, read_n_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   value_q, value_d;
    logic              write_n_q, write_n_d;

    logic              rs1_stall, rs2_stall, rd_stall;
    logic              iss_accept;
    logic              wb_grant;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    // Stall decision looks only at registered busy bits; no same-cycle bypass.
    assign rs1_stall  = iss_rs1_used & busy_q[iss_rs1];
    assign rs2_stall  = iss_rs2_used & busy_q[iss_rs2];
    assign rd_stall   = busy_q[iss_rd];
    assign iss_ready  = ~flush & ~rs1_stall & ~rs2_stall & ~rd_stall;
    assign iss_accept = iss_valid & iss_ready;

    // Contention goes to whichever unit did not win last time.
    assign alu_ready = alu_valid & (~lsu_valid | (last_grant_q == GRANT_LSU));
    assign lsu_ready = lsu_valid & (~alu_valid | (last_grant_q == GRANT_ALU));
    assign wb_grant  = alu_ready | lsu_ready;
    assign wb_rd     = alu_ready ? alu_rd   : lsu_rd;
    assign wb_data   = alu_ready ? alu_data : lsu_data;

    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_ready) begin
            last_grant_d = GRANT_ALU;
        end else if (lsu_ready) begin
            last_grant_d = GRANT_LSU;
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign set_vec[gi] = 1'b0;
                assign clr_vec[gi] = 1'b0;
                assign busy_d[gi]  = 1'b0;
            end else begin : g_reg
                assign set_vec[gi] = iss_accept & (iss_rd == REG_AW'(gi));
                assign clr_vec[gi] = wb_grant & (wb_rd == REG_AW'(gi));
                // Set beats clear so a re-issued destination stays pending.
                assign busy_d[gi]  = ~flush & (set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]));
            end
        end
    endgenerate

    always_comb begin
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        read_n_d = 1'b1;
        if (iss_accept) begin
            rs1_d    = iss_rs1;
            rs2_d    = iss_rs2;
            read_n_d = 1'b0;
        end
    end

    // Writes to x0 consume the grant but never reach the register file.
    always_comb begin
        rd_d      = rd_q;
        value_d   = value_q;
        write_n_d = 1'b1;
        if (wb_grant && (wb_rd != '0)) begin
            rd_d      = wb_rd;
            value_d   = wb_data;
            write_n_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            last_grant_q <= GRANT_LSU;
            rs1_q        <= '0;
            rs2_q        <= '0;
            read_n_q     <= 1'b1;
            rd_q         <= '0;
            value_q      <= '0;
            write_n_q    <= 1'b1;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            read_n_q     <= read_n_d;
            rd_q         <= rd_d;
            value_q      <= value_d;
            write_n_q    <= write_n_d;
        end
    end

    assign rf_rs1_out      = rs1_q;
    assign rf_rs2_out      = rs2_q;
    assign rf_rs_read_n    = read_n_q;
    assign rf_rd_out       = rd_q;
    assign rf_rd_value_out = value_q;
    assign rf_rd_write_n   = write_n_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_regs_wb_scheduler.sv
// Directed bench for regs_wb_scheduler: behavioural model checked every cycle
// plus literal expectations for each scenario.
module tb_regs_wb_scheduler;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              iss_valid;
    logic [REG_AW-1:0] iss_rs1, iss_rs2, iss_rd;
    logic              iss_rs1_used, iss_rs2_used;
    logic              iss_ready;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic              lsu_ready;
    logic [REG_AW-1:0] rf_rs1_out, rf_rs2_out, rf_rd_out;
    logic              rf_rs_read_n, rf_rd_write_n;
    logic [XLEN-1:0]   rf_rd_value_out;
    logic [31:0]       busy_out;

    int n_checks = 0;
    int n_pass   = 0;

    regs_wb_scheduler #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used),
        .iss_rd(iss_rd), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_rs1_out(rf_rs1_out), .rf_rs2_out(rf_rs2_out), .rf_rs_read_n(rf_rs_read_n),
        .rf_rd_out(rf_rd_out), .rf_rd_value_out(rf_rd_value_out),
        .rf_rd_write_n(rf_rd_write_n), .busy_out(busy_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]   m_busy;
    bit          m_last_lsu;
    bit          m_read_n, m_write_n;
    bit [4:0]    m_rs1, m_rs2, m_rd;
    bit [31:0]   m_val;

    function automatic bit exp_iss_ready();
        if (flush) return 1'b0;
        if (iss_rs1_used && m_busy[iss_rs1]) return 1'b0;
        if (iss_rs2_used && m_busy[iss_rs2]) return 1'b0;
        return !m_busy[iss_rd];
    endfunction

    function automatic bit exp_alu_grant();
        return alu_valid && (!lsu_valid || m_last_lsu);
    endfunction

    function automatic bit exp_lsu_grant();
        return lsu_valid && !exp_alu_grant();
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = '0; m_last_lsu = 1'b1;
            m_read_n = 1'b1; m_rs1 = '0; m_rs2 = '0;
            m_write_n = 1'b1; m_rd = '0; m_val = '0;
        end else begin
            bit acc, ag, lg, g;
            bit [4:0] g_rd;
            bit [31:0] g_val;
            acc   = iss_valid && exp_iss_ready();
            ag    = exp_alu_grant();
            lg    = exp_lsu_grant();
            g     = ag || lg;
            g_rd  = ag ? alu_rd : lsu_rd;
            g_val = ag ? alu_data : lsu_data;
            if (flush) m_busy = '0;
            else begin
                if (g) m_busy[g_rd] = 1'b0;
                if (acc && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
            if (ag) m_last_lsu = 1'b0;
            else if (lg) m_last_lsu = 1'b1;
            m_read_n = !acc;
            if (acc) begin m_rs1 = iss_rs1; m_rs2 = iss_rs2; end
            if (g && g_rd != 0) begin
                m_write_n = 1'b0; m_rd = g_rd; m_val = g_val;
            end else m_write_n = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("m_iss_ready", {31'd0, iss_ready}, {31'd0, exp_iss_ready()});
            check("m_alu_ready", {31'd0, alu_ready}, {31'd0, exp_alu_grant()});
            check("m_lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_lsu_grant()});
            check("m_read_n", {31'd0, rf_rs_read_n}, {31'd0, m_read_n});
            check("m_write_n", {31'd0, rf_rd_write_n}, {31'd0, m_write_n});
            check("m_busy", busy_out, m_busy);
            if (!m_read_n) begin
                check("m_rs1", {27'd0, rf_rs1_out}, {27'd0, m_rs1});
                check("m_rs2", {27'd0, rf_rs2_out}, {27'd0, m_rs2});
            end
            if (!m_write_n) begin
                check("m_rd", {27'd0, rf_rd_out}, {27'd0, m_rd});
                check("m_val", rf_rd_value_out, m_val);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        iss_rs1_used = 0; iss_rs2_used = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        do_reset();
        check("rst_busy", busy_out, 32'h0);
        check("rst_write_n", {31'd0, rf_rd_write_n}, 32'd1);
        check("rst_read_n", {31'd0, rf_rs_read_n}, 32'd1);

        // 1: reset while a write is in flight
        alu_valid = 1; alu_rd = 4; alu_data = 32'hA5A5_0004;
        iss_valid = 1; iss_rd = 6;
        step();
        idle();
        check("s1_write_n_pre", {31'd0, rf_rd_write_n}, 32'd0);
        check("s1_busy_pre", busy_out, 32'h0000_0040);
        reset = 1;
        #1;
        check("s1_write_n", {31'd0, rf_rd_write_n}, 32'd1);
        check("s1_busy", busy_out, 32'h0);
        check("s1_rd_out", {27'd0, rf_rd_out}, 32'd0);
        check("s1_value", rf_rd_value_out, 32'h0);
        check("s1_rs1_out", {27'd0, rf_rs1_out}, 32'd0);
        step();
        reset = 0;

        // 2: RAW stall on x5 until ALU writeback
        iss_valid = 1; iss_rd = 5;
        step();
        idle();
        check("s2_busy5", busy_out, 32'h0000_0020);
        iss_valid = 1; iss_rs1 = 5; iss_rs1_used = 1; iss_rd = 0;
        alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_1234;
        #1;
        check("s2_stall", {31'd0, iss_ready}, 32'd0);
        step();
        alu_valid = 0;
        check("s2_write_n", {31'd0, rf_rd_write_n}, 32'd0);
        check("s2_wdata", rf_rd_value_out, 32'h0000_1234);
        check("s2_busy_clr", busy_out, 32'h0);
        check("s2_ready", {31'd0, iss_ready}, 32'd1);
        step();
        idle();
        check("s2_read_n", {31'd0, rf_rs_read_n}, 32'd0);
        check("s2_rs1", {27'd0, rf_rs1_out}, 32'd5);
        step();
        check("s2_read_n_1cyc", {31'd0, rf_rs_read_n}, 32'd1);

        // 3: simultaneous requests alternate starting with ALU
        do_reset();
        alu_valid = 1; alu_rd = 10; alu_data = 32'h1000_000A;
        lsu_valid = 1; lsu_rd = 11; lsu_data = 32'h2000_000B;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("s3_alu_ready", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("s3_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            check("s3_write_n", {31'd0, rf_rd_write_n}, 32'd0);
            check("s3_rd", {27'd0, rf_rd_out}, (i % 2 == 0) ? 32'd10 : 32'd11);
        end
        idle();
        step();
        check("s3_write_n_end", {31'd0, rf_rd_write_n}, 32'd1);

        // 4: issue and writeback to x7 together, set wins
        iss_valid = 1; iss_rd = 7;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h7777_7777;
        step();
        idle();
        check("s4_busy7", busy_out, 32'h0000_0080);
        check("s4_write_n", {31'd0, rf_rd_write_n}, 32'd0);

        // 5: write to x0 is acknowledged but dropped
        alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD_BEEF;
        #1;
        check("s5_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        idle();
        check("s5_write_n", {31'd0, rf_rd_write_n}, 32'd1);

        // 6: flush clears scoreboard, writeback still granted
        iss_valid = 1; iss_rd = 3;
        step();
        iss_rd = 9;
        step();
        idle();
        check("s6_busy", busy_out, 32'h0000_0288);
        flush = 1; iss_valid = 1; iss_rd = 12;
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3333_0003;
        #1;
        check("s6_iss_ready", {31'd0, iss_ready}, 32'd0);
        check("s6_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        idle();
        check("s6_busy_clr", busy_out, 32'h0);
        check("s6_write_n", {31'd0, rf_rd_write_n}, 32'd0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
